// File: rtl/bg_mem_arbiter_pkg.sv
// rtl/bg_mem_arbiter_pkg.sv - shared constants and types for the background frame RAM arbiter
//
// Purpose: frame geometry, bus widths, RAM owner encoding and clear-engine state type.
package bg_mem_arbiter_pkg;

    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 300;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    localparam int BG_ADDR_W = 19;
    localparam int BG_DATA_W = 4;

    // Which requester drives the RAM port in the current cycle.
    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_DISP = 3'd1;
    localparam logic [2:0] OWN_CLR  = 3'd2;
    localparam logic [2:0] OWN_WR   = 3'd3;
    localparam logic [2:0] OWN_RD   = 3'd4;

    typedef enum logic {
        CLR_IDLE   = 1'b0,
        CLR_ACTIVE = 1'b1
    } clr_state_e;

endpackage

// File: rtl/bg_clear_engine.sv
// rtl/bg_clear_engine.sv - full-frame fill engine for the background RAM
//
// Purpose: walks addresses 0..FB_PIXELS-1, advancing only on cycles it is granted the RAM.
// Ports:
//   pclk_i, rst_i      clock, synchronous active-high reset
//   start_i, value_i   start pulse and fill value (sampled on start)
//   grant_i            engine owns the RAM this cycle
//   busy_o             clear in progress
//   cnt_o, val_o       current clear address and fill value
module bg_clear_engine
    import bg_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 4,
    parameter int N_PIXELS = 120000
) (
    input  logic              pclk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              grant_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] cnt_o,
    output logic [DATA_W-1:0] val_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] val_q;
    logic              busy_q;

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (start_i) begin
                        state_q <= CLR_ACTIVE;
                        cnt_q   <= '0;
                        val_q   <= value_i;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_ACTIVE: begin
                    // start_i is ignored here: a running clear is never restarted.
                    if (grant_i) begin
                        if (cnt_q == LAST_ADDR) begin
                            state_q <= CLR_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= CLR_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign cnt_o  = cnt_q;
    assign val_o  = val_q;

endmodule

// File: rtl/bg_mem_arbiter.sv
// rtl/bg_mem_arbiter.sv - single-port background frame RAM arbiter with built-in clear
//
// Purpose: shares the frame RAM between display fetch (highest priority), the clear
// engine, and round-robin game-logic write/read ports.
// Ports:
//   pclk, rst                                  clock, synchronous active-high reset
//   disp_req, disp_addr, disp_rgb              display fetch, 2-cycle latency
//   wr_valid, wr_addr, wr_data, wr_ready       game-logic write port
//   rd_valid, rd_addr, rd_ready, rd_rvalid, rd_rdata   collision probe port
//   clr_start, clr_value, clr_busy             frame clear control
//   addr_err                                   sticky out-of-range access flag
//   mem_addr, mem_we, mem_wdata, mem_rdata     synchronous RAM port
module bg_mem_arbiter #(
    parameter int ADDR_W    = bg_mem_arbiter_pkg::BG_ADDR_W,
    parameter int DATA_W    = bg_mem_arbiter_pkg::BG_DATA_W,
    parameter int FB_PIXELS = bg_mem_arbiter_pkg::FB_PIXELS
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rgb,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              addr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import bg_mem_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] PIX_LIM = ADDR_W'(FB_PIXELS);

    logic [2:0]        owner;
    logic              clr_busy_w;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_val;
    logic              wr_in_range;
    logic              rd_in_range;

    logic              rr_rd_q, rr_rd_d;     // 0: write wins next tie, 1: read wins
    logic              addr_err_q, addr_err_d;
    logic              rd_pend_q;
    logic              rd_oor_q;
    logic              disp_pend_q;
    logic [DATA_W-1:0] disp_rgb_q;

    assign wr_in_range = (wr_addr < PIX_LIM);
    assign rd_in_range = (rd_addr < PIX_LIM);

    always_comb begin
        owner = OWN_NONE;
        if (disp_req) begin
            owner = OWN_DISP;
        end else if (clr_busy_w) begin
            owner = OWN_CLR;
        end else if (wr_valid && rd_valid) begin
            owner = rr_rd_q ? OWN_RD : OWN_WR;
        end else if (wr_valid) begin
            owner = OWN_WR;
        end else if (rd_valid) begin
            owner = OWN_RD;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (owner)
            OWN_DISP: mem_addr = disp_addr;
            OWN_CLR: begin
                mem_addr  = clr_cnt;
                mem_we    = 1'b1;
                mem_wdata = clr_val;
            end
            OWN_WR: begin
                mem_addr  = wr_addr;
                mem_we    = wr_in_range;
                mem_wdata = wr_data;
            end
            OWN_RD:  mem_addr = rd_addr;
            default: mem_addr = '0;
        endcase
    end

    assign wr_ready = (owner == OWN_WR);
    assign rd_ready = (owner == OWN_RD);

    always_comb begin
        rr_rd_d = rr_rd_q;
        // The pointer only moves when it actually broke a tie.
        if (wr_valid && rd_valid && (owner == OWN_WR || owner == OWN_RD)) begin
            rr_rd_d = ~rr_rd_q;
        end
        addr_err_d = addr_err_q
                   | ((owner == OWN_WR) && !wr_in_range)
                   | ((owner == OWN_RD) && !rd_in_range);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rr_rd_q     <= 1'b0;
            addr_err_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_oor_q    <= 1'b0;
            disp_pend_q <= 1'b0;
            disp_rgb_q  <= '0;
        end else begin
            rr_rd_q     <= rr_rd_d;
            addr_err_q  <= addr_err_d;
            rd_pend_q   <= (owner == OWN_RD);
            rd_oor_q    <= (owner == OWN_RD) && !rd_in_range;
            disp_pend_q <= (owner == OWN_DISP);
            // RAM data belongs to whoever owned the previous cycle; only display data lands here.
            if (disp_pend_q) begin
                disp_rgb_q <= mem_rdata;
            end
        end
    end

    assign disp_rgb  = disp_rgb_q;
    assign rd_rvalid = rd_pend_q;
    assign rd_rdata  = (rd_pend_q && !rd_oor_q) ? mem_rdata : '0;
    assign addr_err  = addr_err_q;
    assign clr_busy  = clr_busy_w;

    bg_clear_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .N_PIXELS (FB_PIXELS)
    ) u_clear (
        .pclk_i  (pclk),
        .rst_i   (rst),
        .start_i (clr_start),
        .value_i (clr_value),
        .grant_i (owner == OWN_CLR),
        .busy_o  (clr_busy_w),
        .cnt_o   (clr_cnt),
        .val_o   (clr_val)
    );

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// tb/tb_bg_mem_arbiter.sv - self-checking bench for bg_mem_arbiter
module tb_bg_mem_arbiter;

    localparam int TB_PIX = 1000;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [18:0] disp_addr = '0;
    logic [3:0]  disp_rgb;
    logic        wr_valid = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        wr_ready;
    logic        rd_valid = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        rd_ready;
    logic        rd_rvalid;
    logic [3:0]  rd_rdata;
    logic        clr_start = 1'b0;
    logic [3:0]  clr_value = '0;
    logic        clr_busy;
    logic        addr_err;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;

    int checks = 0;
    int failures = 0;

    bg_mem_arbiter #(.ADDR_W(19), .DATA_W(4), .FB_PIXELS(TB_PIX)) dut (
        .pclk(pclk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rgb(disp_rgb),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
        .addr_err(addr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 pclk = ~pclk;

    // Synchronous RAM model; out-of-range reads return F so masking is visible.
    logic [3:0] ram [0:TB_PIX-1];
    always @(posedge pclk) begin
        if (mem_we && mem_addr < 19'(TB_PIX)) ram[int'(mem_addr)] <= mem_wdata;
        mem_rdata <= (mem_addr < 19'(TB_PIX)) ? ram[int'(mem_addr)] : 4'hF;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pclk);
    endtask

    task automatic idle_inputs();
        disp_req = 0; wr_valid = 0; rd_valid = 0; clr_start = 0;
        disp_addr = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; clr_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc(); cyc();
        rst = 0;
    endtask

    typedef struct {
        logic        disp;
        logic        wv;
        logic        rv;
        logic [18:0] raddr;
        logic        exp_wr;
        logic        exp_rd;
        logic        exp_we;
        logic [18:0] exp_addr;
        logic        exp_rv;
        logic [3:0]  exp_rdata;
    } vec_t;

    function automatic vec_t mk(logic d, logic wv, logic rv, logic [18:0] ra, logic ew, logic er,
                                logic ewe, logic [18:0] ea, logic erv, logic [3:0] erd);
        vec_t v;
        v.disp = d; v.wv = wv; v.rv = rv; v.raddr = ra;
        v.exp_wr = ew; v.exp_rd = er; v.exp_we = ewe; v.exp_addr = ea;
        v.exp_rv = erv; v.exp_rdata = erd;
        return v;
    endfunction

    vec_t vecs [0:8];

    initial begin
        int n_we, bad, grants, found;
        logic done, last;

        // disp_addr=5, wr_addr=10/data 1 are fixed for the whole table.
        vecs[0] = mk(1, 1, 1, 19'd10,     0, 0, 0, 19'd5,      0, 4'h0);
        vecs[1] = mk(0, 1, 1, 19'd10,     1, 0, 1, 19'd10,     0, 4'h0);
        vecs[2] = mk(0, 1, 1, 19'd10,     0, 1, 0, 19'd10,     0, 4'h0);
        vecs[3] = mk(0, 1, 1, 19'd10,     1, 0, 1, 19'd10,     1, 4'h1);
        vecs[4] = mk(0, 1, 1, 19'd10,     0, 1, 0, 19'd10,     0, 4'h0);
        vecs[5] = mk(0, 0, 1, 19'd10,     0, 1, 0, 19'd10,     1, 4'h1);
        vecs[6] = mk(0, 0, 0, 19'd10,     0, 0, 0, 19'd0,      1, 4'h1);
        vecs[7] = mk(0, 0, 1, 19'd200000, 0, 1, 0, 19'd200000, 0, 4'h0);
        vecs[8] = mk(0, 0, 0, 19'd0,      0, 0, 0, 19'd0,      1, 4'h0);

        do_reset();
        #1;
        chk("rst_disp_rgb", disp_rgb, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_rd_rvalid", rd_rvalid, 0);
        chk("rst_mem_we", mem_we, 0);

        // Display priority and 2-cycle latency.
        cyc(); wr_valid = 1; wr_addr = 5; wr_data = 4'hA; #1;
        chk("t1_wr_ready", wr_ready, 1);
        cyc(); wr_valid = 1; rd_valid = 1; disp_req = 1; disp_addr = 5; #1;
        chk("t1_d0_wr_ready", wr_ready, 0);
        chk("t1_d0_rd_ready", rd_ready, 0);
        chk("t1_d0_mem_addr", mem_addr, 5);
        cyc(); #1;
        chk("t1_d1_disp_rgb", disp_rgb, 0);
        chk("t1_d1_grants", {wr_ready, rd_ready}, 0);
        cyc(); #1;
        chk("t1_d2_disp_rgb", disp_rgb, 4'hA);
        chk("t1_d2_grants", {wr_ready, rd_ready}, 0);

        // Round-robin table.
        wr_addr = 10; wr_data = 1; disp_addr = 5;
        for (int i = 0; i < 9; i++) begin
            cyc();
            disp_req = vecs[i].disp; wr_valid = vecs[i].wv; rd_valid = vecs[i].rv;
            rd_addr = vecs[i].raddr;
            #1;
            chk($sformatf("tab%0d_wr_ready", i), wr_ready, vecs[i].exp_wr);
            chk($sformatf("tab%0d_rd_ready", i), rd_ready, vecs[i].exp_rd);
            chk($sformatf("tab%0d_mem_we", i), mem_we, vecs[i].exp_we);
            chk($sformatf("tab%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("tab%0d_rd_rvalid", i), rd_rvalid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk($sformatf("tab%0d_rd_rdata", i), rd_rdata, vecs[i].exp_rdata);
        end
        chk("tab_addr_err_oor_read", addr_err, 1);

        // Boundary addresses.
        do_reset();
        cyc(); wr_valid = 1; wr_addr = 19'(TB_PIX - 1); wr_data = 3; #1;
        chk("t3_wr_ready", wr_ready, 1);
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_addr", mem_addr, TB_PIX - 1);
        cyc(); wr_valid = 0; rd_valid = 1; rd_addr = 19'(TB_PIX - 1); #1;
        chk("t3_rd_ready", rd_ready, 1);
        cyc(); rd_valid = 0; #1;
        chk("t3_rd_rvalid", rd_rvalid, 1);
        chk("t3_rd_rdata", rd_rdata, 3);
        chk("t3_addr_err0", addr_err, 0);
        cyc(); wr_valid = 1; wr_addr = 19'(TB_PIX); wr_data = 5; #1;
        chk("t3_oor_wr_ready", wr_ready, 1);
        chk("t3_oor_mem_we", mem_we, 0);
        cyc(); wr_valid = 0; #1;
        chk("t3_addr_err1", addr_err, 1);
        repeat (3) cyc();
        #1;
        chk("t3_addr_err_sticky", addr_err, 1);

        // Full clear with display stealing every other cycle.
        do_reset();
        cyc(); clr_start = 1; clr_value = 7; #1;
        cyc(); clr_start = 0; clr_value = 0; wr_valid = 1; rd_valid = 1; wr_addr = 3; rd_addr = 4; #1;
        chk("t4_busy", clr_busy, 1);
        n_we = 0; bad = 0; grants = 0; done = 0;
        for (int i = 0; i < 10 * TB_PIX && !done; i++) begin
            disp_req = (i % 2) == 1;
            #1;
            if (wr_ready || rd_ready) grants++;
            if (mem_we) begin
                if (mem_addr != 19'(n_we) || mem_wdata != 4'd7 || disp_req) bad++;
                n_we++;
            end
            last = mem_we && (mem_addr == 19'(TB_PIX - 1));
            cyc();
            if (last) begin
                #1;
                chk("t4_busy_fall", clr_busy, 0);
                done = 1;
            end
        end
        chk("t4_done", done, 1);
        chk("t4_we_count", n_we, TB_PIX);
        chk("t4_order_errs", bad, 0);
        chk("t4_grants", grants, 0);
        idle_inputs();

        // Reset in the middle of a clear.
        do_reset();
        cyc(); clr_start = 1; clr_value = 5; #1;
        cyc(); clr_start = 0;
        found = 0;
        for (int i = 0; i < 2 * TB_PIX && found == 0; i++) begin
            #1;
            if (mem_we && mem_addr == 19'd500) found = 1;
            else cyc();
        end
        chk("t5_reached_500", found, 1);
        rst = 1;
        cyc(); rst = 0; #1;
        chk("t5_busy_after_rst", clr_busy, 0);
        chk("t5_we_after_rst", mem_we, 0);
        clr_start = 1; clr_value = 2;
        cyc(); clr_start = 0; #1;
        chk("t5_restart_busy", clr_busy, 1);
        chk("t5_restart_addr", mem_addr, 0);
        chk("t5_restart_data", mem_wdata, 2);
        do_reset();

        // Read immediately before the display resumes.
        cyc(); wr_valid = 1; wr_addr = 30; wr_data = 6; #1;
        cyc(); wr_addr = 40; wr_data = 9; #1;
        cyc(); wr_valid = 0; disp_req = 1; disp_addr = 40; #1;
        cyc(); cyc(); cyc(); #1;
        chk("t6_disp_pre", disp_rgb, 9);
        cyc(); disp_req = 0; rd_valid = 1; rd_addr = 30; #1;
        chk("t6_rd_ready", rd_ready, 1);
        cyc(); rd_valid = 0; disp_req = 1; #1;
        chk("t6_rd_rvalid", rd_rvalid, 1);
        chk("t6_rd_rdata", rd_rdata, 6);
        chk("t6_disp_b0", disp_rgb, 9);
        cyc(); #1;
        chk("t6_disp_b1", disp_rgb, 9);
        chk("t6_rvalid_gone", rd_rvalid, 0);
        cyc(); #1;
        chk("t6_disp_b2", disp_rgb, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
